restoring_divider_seq: RTL and testbench

- Sequential signed two's-complement divider; the inverse counterpart of the Booth multiplier datapath.
- Uses the same A/Q/M shift-register formulation, but runs restoring division, one quotient bit per clock.
- Operands are accepted via a start/busy/done handshake. Quotient and remainder are held until the next accepted start.
- Sits beside the multiplier in the arithmetic unit.

---
 rtl/restoring_divider_seq.sv | 121 ++++++++++++
 tb/tb_restoring_divider_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_seq.sv
// Sequential signed restoring divider: sign-magnitude A/Q/M datapath, one quotient bit per clock.
// start/busy/done handshake; results and flags hold until the next operation's FIX step.
module restoring_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t            state, next;
  logic [WIDTH:0]    a;
  logic [WIDTH-1:0]  q, m;
  logic [CW-1:0]     count;
  logic              sign_q, sign_r, zdiv;

  logic [2*WIDTH:0]  aq_sh;
  logic [WIDTH:0]    a_sh, t;
  logic [WIDTH-1:0]  q_sh, dvd_mag, dvs_mag, q_fix, r_fix;
  logic              accept;

  assign accept  = (state == IDLE) && start;
  assign dvd_mag = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;

  // Shift the whole {A,Q} pair; A's top bit falls out because A < M before each step.
  assign aq_sh = {a, q} << 1;
  assign a_sh  = aq_sh[2*WIDTH:WIDTH];
  assign q_sh  = aq_sh[WIDTH-1:0];
  assign t     = a_sh - {1'b0, m};

  assign q_fix = sign_q ? WIDTH'(-q) : q;
  assign r_fix = sign_r ? WIDTH'(-a[WIDTH-1:0]) : a[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = (divisor == '0) ? FIX : ITER;
      ITER: if (count == CW'(1)) next = FIX;
      FIX:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zdiv      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r <= dividend[WIDTH-1];
          m      <= dvs_mag;
          // A zero divisor skips iteration, so Q carries the raw dividend to FIX.
          q      <= (divisor == '0) ? dividend : dvd_mag;
          zdiv   <= (divisor == '0);
          a      <= '0;
          count  <= CW'(WIDTH);
          busy   <= 1'b1;
        end
        ITER: begin
          count <= count - CW'(1);
          if (t[WIDTH]) begin
            a <= a_sh;
            q <= {q_sh[WIDTH-1:1], 1'b0};
          end else begin
            a <= t;
            q <= {q_sh[WIDTH-1:1], 1'b1};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zdiv) begin
            quotient  <= '1;
            remainder <= q;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= 1'b0;
            overflow  <= !sign_q && (q == {1'b1, {(WIDTH-1){1'b0}}});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed + random bench for restoring_divider_seq against an integer-arithmetic reference.
module tb_restoring_divider_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] pq, pr, eq, er;
  logic         edz, eov;
  int           lat;

  restoring_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division (truncating), with the two special cases.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    dz = 1'b0; ov = 1'b0;
    if (sy == 0) begin
      q = '1; r = x; dz = 1'b1;
    end else if (sx == -(1 << (W-1)) && sy == -1) begin
      q = W'(1 << (W-1)); r = '0; ov = 1'b1;
    end else begin
      q = W'(sx / sy);
      r = W'(sx % sy);
    end
  endtask

  // Called at #1 after a rising edge with the divider idle (or finishing).
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    model(x, y, eq, er, edz, eov);
    lat = edz ? 1 : W + 1;
    start = 1'b1; dividend = x; divisor = y;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    chk("accept_busy", {31'b0, busy}, 32'd1);
    chk("accept_done_low", {31'b0, done}, 32'd0);
    chk("hold_quotient", {24'b0, quotient}, {24'b0, pq});
    chk("hold_remainder", {24'b0, remainder}, {24'b0, pr});
  endtask

  task automatic wait_done(input bit spam);
    int n, busy_cnt;
    bit got;
    n = 0; busy_cnt = 1; got = 0;
    while (n < 30 && !got) begin
      if (spam) begin
        start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("quotient", {24'b0, quotient}, {24'b0, eq});
    chk("remainder", {24'b0, remainder}, {24'b0, er});
    chk("div_zero", {31'b0, div_zero}, {31'b0, edz});
    chk("overflow", {31'b0, overflow}, {31'b0, eov});
    chk("done_busy_low", {31'b0, busy}, 32'd0);
    if (!edz) chk("busy_cycles", busy_cnt, W + 1);
    pq = eq; pr = er;
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(x, y);
    wait_done(1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    pq = '0; pr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", {24'b0, quotient}, 32'd0);
    chk("rst_r", {24'b0, remainder}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_ov", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Prime outputs with a real result so the abort visibly clears them.
    run(8'd100, 8'd7);

    // Abort mid-iteration.
    start_op(8'd50, 8'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_q", {24'b0, quotient}, 32'd0);
    chk("abort_r", {24'b0, remainder}, 32'd0);
    chk("abort_flags", {30'b0, div_zero, overflow}, 32'd0);
    pq = '0; pr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    run(8'd9, 8'd3);

    run(8'd100, 8'd7);
    run(8'h9C, 8'd7);
    run(8'd100, 8'hF9);
    run(8'h9C, 8'hF9);
    run(8'h80, 8'hFF);
    run(8'h80, 8'd1);
    run(8'h80, 8'd0);
    run(8'd5, 8'd0);
    run(8'd5, 8'd5);
    run(8'd127, 8'h80);
    run(8'h80, 8'h80);

    // start hammered during an operation must not disturb it.
    start_op(8'd77, 8'd5);
    wait_done(1'b1);
    @(posedge clk); #1;
    chk("spam_done_one_cycle", {31'b0, done}, 32'd0);

    // start asserted in the done cycle is accepted immediately.
    start_op(8'd0, 8'd9);
    wait_done(1'b0);
    start_op(8'd3, 8'd9);
    wait_done(1'b0);
    start_op(8'd5, 8'd0);
    wait_done(1'b0);
    start_op(8'hF1, 8'd4);
    wait_done(1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run(x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
